// File: rtl/median_row_sequencer_if.sv
// median_row_sequencer_if: bundles the control, window-request, write-back and status signals of the row sequencer
// master: sequencer side (drives requests and status); slave: environment side (drives start/abort and handshakes)
interface median_row_sequencer_if #(
  parameter int AW = 8
) ();
  logic          start;
  logic          abort;
  logic          win_valid;
  logic          win_ready;
  logic [AW-1:0] win_top;
  logic [AW-1:0] win_mid;
  logic [AW-1:0] win_bot;
  logic          filt_done;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   rows_done;
  modport master (
    input  start, abort, win_ready, filt_done, out_ready,
    output win_valid, win_top, win_mid, win_bot, out_valid, out_addr, busy, done, err, rows_done
  );
  modport slave (
    output start, abort, win_ready, filt_done, out_ready,
    input  win_valid, win_top, win_mid, win_bot, out_valid, out_addr, busy, done, err, rows_done
  );
endinterface

// File: rtl/median_row_sequencer.sv
// median_row_sequencer: walks a frame row by row, issuing 3-line windows with edge replication, waiting on the filter under a watchdog, and handing each row to write-back
// clk_i/rst_i: clock and synchronous active-high reset; bus: master side of median_row_sequencer_if
module median_row_sequencer #(
  parameter int ROWS    = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input logic                    clk_i,
  input logic                    rst_i,
  median_row_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;
  localparam logic [AW-1:0] LAST   = AW'(ROWS - 1);
  localparam logic [TW-1:0] WD_MAX = TW'(TIMEOUT - 1);
  state_t        state_q;
  logic [AW-1:0] r_q, top_q, mid_q, bot_q, oaddr_q, r_inc;
  logic [TW-1:0] wd_q;
  logic [AW:0]   rows_q;
  logic          wv_q, ov_q, done_q, err_q;
  function automatic logic [AW-1:0] up_row(input logic [AW-1:0] i);
    return i == '0 ? '0 : i - 1'b1;
  endfunction
  function automatic logic [AW-1:0] dn_row(input logic [AW-1:0] i);
    return i == LAST ? LAST : i + 1'b1;
  endfunction
  assign r_inc = r_q + 1'b1;
  // Window addresses are latched when ISSUE is entered, so they stay stable across a stalled request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      r_q     <= '0;
      wd_q    <= '0;
      rows_q  <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      oaddr_q <= '0;
      wv_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wv_q   <= 1'b0;
      ov_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q != IDLE && bus.abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (bus.start) begin
            state_q <= ISSUE;
            r_q     <= '0;
            rows_q  <= '0;
            wv_q    <= 1'b1;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= dn_row('0);
          end
          ISSUE: if (bus.win_ready) begin
            state_q <= WAIT;
            wd_q    <= '0;
          end else begin
            wv_q <= 1'b1;
          end
          WAIT: if (bus.filt_done) begin
            state_q <= WRITE;
            ov_q    <= 1'b1;
            oaddr_q <= r_q;
          end else if (wd_q == WD_MAX) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
          WRITE: if (bus.out_ready) begin
            rows_q <= rows_q + 1'b1;
            if (r_q == LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              r_q     <= r_inc;
              wv_q    <= 1'b1;
              top_q   <= up_row(r_inc);
              mid_q   <= r_inc;
              bot_q   <= dn_row(r_inc);
            end
          end else begin
            ov_q <= 1'b1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.win_valid = wv_q;
  assign bus.win_top   = top_q;
  assign bus.win_mid   = mid_q;
  assign bus.win_bot   = bot_q;
  assign bus.out_valid = ov_q;
  assign bus.out_addr  = oaddr_q;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rows_done = rows_q;
endmodule

// File: tb/tb_median_row_sequencer.sv
// tb_median_row_sequencer: directed checks of the row sequencer with ROWS=4 and ROWS=1 instances
module tb_median_row_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_err = 0;
  int   n_chk = 0;
  int   tops[4] = '{0, 0, 1, 2};
  int   bots[4] = '{1, 2, 3, 3};
  always #5 clk = ~clk;
  median_row_sequencer_if #(.AW(3)) ifa ();
  median_row_sequencer_if #(.AW(1)) ifb ();
  median_row_sequencer #(.ROWS(4), .AW(3), .TIMEOUT(8), .TW(4)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  median_row_sequencer #(.ROWS(1), .AW(1), .TIMEOUT(8), .TW(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic win(input string tag, input int t, input int m, input int b);
    chk({tag, "_valid"}, 32'(ifa.win_valid), 1);
    chk({tag, "_top"}, 32'(ifa.win_top), t);
    chk({tag, "_mid"}, 32'(ifa.win_mid), m);
    chk({tag, "_bot"}, 32'(ifa.win_bot), b);
  endtask
  initial begin
    ifa.start = 0; ifa.abort = 0; ifa.win_ready = 0; ifa.filt_done = 0; ifa.out_ready = 0;
    ifb.start = 0; ifb.abort = 0; ifb.win_ready = 0; ifb.filt_done = 0; ifb.out_ready = 0;
    tick;
    tick;
    chk("rst_flags", 32'({ifa.win_valid, ifa.out_valid, ifa.busy, ifa.done, ifa.err}), 0);
    chk("rst_addr", 32'({ifa.win_top, ifa.win_mid, ifa.win_bot, ifa.out_addr}), 0);
    chk("rst_rows", 32'(ifa.rows_done), 0);
    rst = 0;
    // full frame, all handshakes immediate
    ifa.win_ready = 1; ifa.filt_done = 1; ifa.out_ready = 1;
    ifa.start = 1;
    tick;
    ifa.start = 0;
    for (int k = 0; k < 4; k++) begin
      win("full_win", tops[k], k, bots[k]);
      tick;
      chk("full_wait_busy", 32'(ifa.busy), 1);
      chk("full_wait_wv", 32'(ifa.win_valid), 0);
      tick;
      chk("full_out_valid", 32'(ifa.out_valid), 1);
      chk("full_out_addr", 32'(ifa.out_addr), k);
      tick;
    end
    chk("full_done", 32'(ifa.done), 1);
    chk("full_rows", 32'(ifa.rows_done), 4);
    tick;
    chk("full_done_end", 32'(ifa.done), 0);
    chk("full_idle_busy", 32'(ifa.busy), 0);
    chk("full_rows_hold", 32'(ifa.rows_done), 4);
    // win_ready stalled on row 2
    ifa.start = 1;
    tick;
    ifa.start = 0;
    repeat (6) tick;
    ifa.win_ready = 0;
    win("stall_win0", 1, 2, 3);
    for (int i = 0; i < 5; i++) begin
      tick;
      win("stall_win", 1, 2, 3);
    end
    ifa.win_ready = 1;
    tick;
    tick;
    chk("stall_out_addr", 32'(ifa.out_addr), 2);
    tick;
    win("stall_next", 2, 3, 3);
    repeat (3) tick;
    chk("stall_done", 32'(ifa.done), 1);
    chk("stall_rows", 32'(ifa.rows_done), 4);
    tick;
    // watchdog timeout
    ifa.filt_done = 0;
    ifa.start = 1;
    tick;
    ifa.start = 0;
    tick;
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("to_err_early", 32'(ifa.err), 0);
      chk("to_busy", 32'(ifa.busy), 1);
    end
    tick;
    chk("to_err", 32'(ifa.err), 1);
    chk("to_busy_after", 32'(ifa.busy), 0);
    chk("to_no_done", 32'(ifa.done), 0);
    tick;
    chk("to_err_once", 32'(ifa.err), 0);
    chk("to_no_done2", 32'(ifa.done), 0);
    ifa.filt_done = 1;
    // abort while row 1 is offered for write-back
    ifa.out_ready = 0;
    ifa.start = 1;
    tick;
    ifa.start = 0;
    tick;
    tick;
    chk("ab_ov0", 32'(ifa.out_valid), 1);
    ifa.out_ready = 1;
    tick;
    ifa.out_ready = 0;
    chk("ab_rows1", 32'(ifa.rows_done), 1);
    tick;
    tick;
    chk("ab_ov1", 32'(ifa.out_valid), 1);
    chk("ab_addr1", 32'(ifa.out_addr), 1);
    ifa.abort = 1;
    tick;
    ifa.abort = 0;
    chk("ab_ov_off", 32'(ifa.out_valid), 0);
    chk("ab_busy", 32'(ifa.busy), 0);
    chk("ab_rows", 32'(ifa.rows_done), 1);
    chk("ab_no_done", 32'(ifa.done), 0);
    tick;
    chk("ab_no_done2", 32'(ifa.done), 0);
    chk("ab_rows_hold", 32'(ifa.rows_done), 1);
    // reset in WAIT of row 2
    ifa.out_ready = 1;
    ifa.start = 1;
    tick;
    ifa.start = 0;
    repeat (7) tick;
    chk("mr_busy", 32'(ifa.busy), 1);
    chk("mr_rows", 32'(ifa.rows_done), 2);
    rst = 1;
    tick;
    rst = 0;
    chk("mr_flags", 32'({ifa.win_valid, ifa.out_valid, ifa.busy, ifa.done, ifa.err}), 0);
    chk("mr_addr", 32'({ifa.win_top, ifa.win_mid, ifa.win_bot, ifa.out_addr}), 0);
    chk("mr_rows0", 32'(ifa.rows_done), 0);
    ifa.start = 1;
    tick;
    ifa.start = 0;
    win("mr_restart", 0, 0, 1);
    ifa.abort = 1;
    tick;
    ifa.abort = 0;
    chk("mr_abort_busy", 32'(ifa.busy), 0);
    // ROWS=1 with start held high
    ifb.win_ready = 1; ifb.filt_done = 1; ifb.out_ready = 1;
    ifb.start = 1;
    tick;
    chk("r1_wv", 32'(ifb.win_valid), 1);
    chk("r1_win", 32'({ifb.win_top, ifb.win_mid, ifb.win_bot}), 0);
    tick;
    tick;
    chk("r1_ov", 32'(ifb.out_valid), 1);
    chk("r1_addr", 32'(ifb.out_addr), 0);
    tick;
    chk("r1_done", 32'(ifb.done), 1);
    chk("r1_rows", 32'(ifb.rows_done), 1);
    tick;
    chk("r1_idle", 32'(ifb.busy), 0);
    chk("r1_done_once", 32'(ifb.done), 0);
    chk("r1_no_wv", 32'(ifb.win_valid), 0);
    tick;
    chk("r1_restart", 32'(ifb.win_valid), 1);
    ifb.start = 0;
    ifb.abort = 1;
    tick;
    ifb.abort = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
